apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Parametrised APB4 master bridge, successor to the single-slave fixed-width APB wrapper. Converts a simple valid/ready request port into APB4 SETUP/ACCESS transfers to up to `NUM_SLAVES` slaves. It adds address decode, byte strobes, PSLVERR reporting and an optional wait-state timeout. It sits between the system-side register-access master and the APB slave fabric.

## Interface
- `ADDR_W`, 9: request/PADDR address width.
- `DATA_W`, 8: data width; multiple of 8.
- `NUM_SLAVES`, 2: number of PSEL lines; 1..16.
- `TIMEOUT_CYC`, 16: maximum ACCESS cycles before abort; used only with `APB_TIMEOUT_EN`.
- `clk  in  1`: clock.
- `PRESET  in  1`: asynchronous, active-high reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: bridge accepts a request this cycle.
- `req_write  in  1`: 1 = write, 0 = read.
- `req_addr  in  ADDR_W`: target address.
- `req_wdata  in  DATA_W`: write data.
- `req_strb  in  DATA_W/8`: write byte enables.
- `rsp_valid  out  1`: one-cycle response pulse.
- `rsp_rdata  out  DATA_W`: read data; 0 for writes and errors.
- `rsp_err  out  1`: PSLVERR, decode error or timeout.
- `PSEL  out  NUM_SLAVES`: one-hot slave select.
- `PENABLE  out  1`, `PWRITE  out  1`, `PADDR  out  ADDR_W`, `PWDATA  out  DATA_W`, `PSTRB  out  DATA_W/8`: APB4 master outputs.
- `PRDATA  in  NUM_SLAVES*DATA_W`: per-slave read data, slave 0 in the LSBs.
- `PREADY  in  NUM_SLAVES`, `PSLVERR  in  NUM_SLAVES`: per-slave handshake and error inputs.

## Operation
- Decode: `SEL_W = $clog2(NUM_SLAVES)`, with a minimum of 1. The slave index is `req_addr[ADDR_W-1 -: SEL_W]`. An index of `NUM_SLAVES` or greater is a decode error. When `NUM_SLAVES=1`, index 0 is always used.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch write, addr, wdata, strb and slave index.
  - Valid index: go to SETUP.
  - Decode error: go to RESP with `rsp_err=1`. No PSEL is asserted.
- SETUP: PSEL[idx]=1, PENABLE=0, then ACCESS unconditionally.
- ACCESS: PSEL[idx]=1, PENABLE=1. Wait for PREADY[idx].
  - On PREADY[idx], capture PSLVERR[idx] and, for reads, PRDATA slice idx, then go to RESP.
  - PREADY and PSLVERR of unselected slaves are ignored.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE. `req_ready=0`.
- PADDR, PWRITE, PWDATA and PSTRB are held stable from SETUP through ACCESS. They hold their last values in IDLE/RESP. PSTRB is forced to 0 on reads.
- `rsp_rdata` is 0 when `rsp_err=1` or for writes.
- A read with PSLVERR=1 returns `rsp_err=1` and `rsp_rdata=0`.
- There is no response backpressure; the consumer must accept the `rsp_valid` pulse.

## Timing
- Reset (asynchronous, immediate): state IDLE. `req_ready`=0 while PRESET is high, then 1. `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0.
- Zero-wait transfer: request accepted at cycle 0, SETUP at cycle 1, ACCESS with PREADY at cycle 2, `rsp_valid` at cycle 3, next accept at cycle 4.
- Each wait state adds one ACCESS cycle.
- Decode error: accepted at cycle 0, `rsp_valid`/`rsp_err` at cycle 1.
- `req_valid` outside IDLE is ignored; the requester holds it until `req_ready`.
- Reset mid-transfer aborts it: PSEL and PENABLE drop in the same cycle, and no response is issued.

## Configuration
- Macro `APB_TIMEOUT_EN`.
  - Defined: an ACCESS cycle counter of width `$clog2(TIMEOUT_CYC+1)` runs.
  - If PREADY[idx] is not seen by the `TIMEOUT_CYC`-th ACCESS cycle, the transfer is terminated: PSEL and PENABLE drop, then RESP with `rsp_err=1` and `rsp_rdata=0`.
  - PREADY arriving on that same cycle wins; normal completion applies.
  - Undefined: no counter, and ACCESS waits indefinitely.

## Structure
- `apb_pkg`: state enum `apb_state_e` (IDLE, SETUP, ACCESS, RESP) and an `apb_req_t` struct (write, addr, wdata, strb).
- Sub-module `apb_addr_decoder`: combinational index extraction, valid flag and one-hot PSEL generation. Parametrised by `ADDR_W` and `NUM_SLAVES`.

## Test plan
- Write, `ADDR_W=9`, `NUM_SLAVES=2`, addr 0x105, wdata 0xA5, strb 1, slave 1 zero-wait → PSEL=2'b10 cycles 1-2, PENABLE cycle 2 only, PSTRB=1, `rsp_valid` cycle 3 with `rsp_err=0`.
- Read addr 0x010, slave 0 with 3 wait states and PRDATA=0x3C → ACCESS lasts 4 cycles, PSTRB=0, `rsp_rdata`=0x3C, and PRDATA of slave 1 has no effect.
- `NUM_SLAVES=3`, addr index 3 → no PSEL, `rsp_valid` and `rsp_err`=1 one cycle after accept.
- Slave asserts PSLVERR with PREADY on a read → `rsp_err=1`, `rsp_rdata=0`.
- `APB_TIMEOUT_EN`, `TIMEOUT_CYC=4`, PREADY held low → PSEL drops after 4 ACCESS cycles, then `rsp_err=1`. Without the macro, the bridge is still in ACCESS after 100 cycles.
- PRESET asserted during ACCESS → PSEL, PENABLE and `rsp_valid` are 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared types for the APB4 master bridge: the bridge FSM state encoding,
//   the latched request record, and a helper that sizes the slave-index field.
//
//   apb_req_t is sized for the widest supported configuration
//   (ADDR_W <= 32, DATA_W <= 64). Narrower instances fill the low bits and
//   leave the rest zero.
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned APB_MAX_ADDR_W = 32;
    localparam int unsigned APB_MAX_DATA_W = 64;
    localparam int unsigned APB_MAX_STRB_W = APB_MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_MAX_ADDR_W-1:0] addr;
        logic [APB_MAX_DATA_W-1:0] wdata;
        logic [APB_MAX_STRB_W-1:0] strb;
    } apb_req_t;

    // Width of the slave-index field. A single slave still gets one bit, so
    // the index vector never collapses to zero width.
    function automatic int unsigned sel_width(input int unsigned num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
//   Bundles the bridge's request/response port and its APB4 master port.
//
//   modport master : the bridge's view (drives req_ready, rsp_*, PSEL,
//                    PENABLE, PWRITE, PADDR, PWDATA, PSTRB).
//   modport slave  : the environment's view (requester plus APB slave fabric).
//
//   Parameters: ADDR_W, DATA_W (multiple of 8), NUM_SLAVES (1..16).
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_SLAVES = 2
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // Request / response side
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic [STRB_W-1:0]            req_strb;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    // APB4 side
    logic [NUM_SLAVES-1:0]        PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [ADDR_W-1:0]            PADDR;
    logic [DATA_W-1:0]            PWDATA;
    logic [STRB_W-1:0]            PSTRB;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge_decoder.sv
// -----------------------------------------------------------------------------
// apb_addr_decoder
//   Combinational slave decode. The slave index is the top SEL_W address bits;
//   an index at or beyond NUM_SLAVES is flagged as a decode error and selects
//   nothing. With a single slave, index 0 is always used.
//
//   Ports:
//     addr  in  ADDR_W      request address
//     valid out 1           index addresses an existing slave
//     sel   out NUM_SLAVES  one-hot select (all zero when !valid)
// -----------------------------------------------------------------------------
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned NUM_SLAVES = 2
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic                  valid,
    output logic [NUM_SLAVES-1:0] sel
);
    localparam int unsigned SEL_W = sel_width(NUM_SLAVES);

    logic [SEL_W-1:0] idx;

    if (NUM_SLAVES == 1) begin : g_single
        assign idx   = '0;
        assign valid = 1'b1;
    end else begin : g_multi
        assign idx   = addr[ADDR_W-1 -: SEL_W];
        assign valid = (32'(idx) < NUM_SLAVES);
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = valid && (32'(idx) == 32'(i));
        end
    end

    // Only the index bits carry meaning; the rest of the address is folded
    // here so the whole input vector counts as consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB4 master bridge: turns a valid/ready request into an APB4 SETUP/ACCESS
//   transfer to one of NUM_SLAVES slaves, then returns a single-cycle
//   response pulse. Address decode errors are answered directly without any
//   APB activity.
//
//   Parameters: ADDR_W (<=32), DATA_W (multiple of 8, <=64),
//               NUM_SLAVES (1..16), TIMEOUT_CYC (only with APB_TIMEOUT_EN).
//
//   Ports:
//     clk     in  clock
//     PRESET  in  asynchronous, active-high reset
//     bus     apb_master_bridge_if.master (request, response and APB4 signals)
//
//   Build option: define APB_TIMEOUT_EN to abort an ACCESS phase that has not
//   seen PREADY by its TIMEOUT_CYC-th cycle (answered with rsp_err=1). Without
//   it, ACCESS waits indefinitely.
//
//   Latency (zero wait states): accept at cycle 0, SETUP 1, ACCESS 2,
//   rsp_valid 3, next accept 4. Decode error: rsp_valid at cycle 1.
// -----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SLAVES  = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    apb_state_e            state;
    apb_req_t              req_q;      // request owning the APB bus
    apb_req_t              new_req;
    logic [NUM_SLAVES-1:0] psel_q;     // one-hot form of the latched slave index
    logic                  penable_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;

    logic                  dec_valid;
    logic [NUM_SLAVES-1:0] dec_sel;

    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [DATA_W-1:0]     prdata_sel;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;         // number of the current ACCESS cycle
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    apb_addr_decoder #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_addr_decoder (
        .addr  (bus.req_addr),
        .valid (dec_valid),
        .sel   (dec_sel)
    );

    // Request as it will be latched; PSTRB must be zero on reads.
    always_comb begin
        new_req                   = '0;
        new_req.write             = bus.req_write;
        new_req.addr[ADDR_W-1:0]  = bus.req_addr;
        new_req.wdata[DATA_W-1:0] = bus.req_wdata;
        new_req.strb[STRB_W-1:0]  = bus.req_write ? bus.req_strb : '0;
    end

    // Pick the selected slave's handshake using the held one-hot select, so
    // unselected slaves' PREADY/PSLVERR/PRDATA never reach the FSM.
    always_comb begin
        pready_sel  = |(bus.PREADY & psel_q);
        pslverr_sel = |(bus.PSLVERR & psel_q);
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) begin
                prdata_sel = bus.PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            req_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every branch below sees the values from before this edge.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (dec_valid) begin
                            req_q  <= new_req;
                            psel_q <= dec_sel;
                            state  <= SETUP;
                        end else begin
                            // No slave behind this address: answer at once
                            // and leave the APB outputs untouched.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt   <= TMO_W'(1);
`endif
                end

                ACCESS: begin
                    // PREADY is checked first so it wins over a timeout that
                    // falls on the same cycle.
                    if (pready_sel) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr_sel;
                        rsp_rdata_q <= (!req_q.write && !pslverr_sel) ? prdata_sel : '0;
                        state       <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC)) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ready is decoded from state but masked by reset so it is low for the
    // whole reset window and high as soon as reset releases.
    assign bus.req_ready = (state == IDLE) && !PRESET;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = req_q.write;
    assign bus.PADDR     = req_q.addr[ADDR_W-1:0];
    assign bus.PWDATA    = req_q.wdata[DATA_W-1:0];
    assign bus.PSTRB     = req_q.strb[STRB_W-1:0];

    // Bits of req_q above the configured widths stay zero and are never
    // driven out; fold them so the register counts as fully consumed.
    logic unused_req_bits;
    assign unused_req_bits = ^req_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge. A 2-slave bridge (TIMEOUT_CYC=4)
//   carries most traffic; a 3-slave bridge covers decode errors. Expected
//   responses are queued when a request is issued and compared when rsp_valid
//   is seen. Compile with APB_TIMEOUT_EN to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    logic clk    = 1'b0;
    logic PRESET = 1'b1;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2)) bus ();
    apb_master_bridge_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(3)) bus3 ();

    apb_master_bridge #(
        .ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2), .TIMEOUT_CYC(4)
    ) u_dut (
        .clk    (clk),
        .PRESET (PRESET),
        .bus    (bus)
    );

    apb_master_bridge #(
        .ADDR_W(9), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT_CYC(16)
    ) u_dut3 (
        .clk    (clk),
        .PRESET (PRESET),
        .bus    (bus3)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_rsp_t;

    exp_rsp_t exp_q[$];
    exp_rsp_t exp3_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboards: every rsp_valid pulse must match the oldest
    // outstanding expectation of its bridge.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_rsp_t e;
                e = exp_q.pop_front();
                check("rsp_err", bus.rsp_err, e.err);
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
            end
        end
        if (bus3.rsp_valid) begin
            if (exp3_q.size() == 0) begin
                check("rsp3_unexpected", 64'(exp3_q.size()), 64'd1);
            end else begin
                exp_rsp_t e;
                e = exp3_q.pop_front();
                check("rsp3_err", bus3.rsp_err, e.err);
                check("rsp3_rdata", bus3.rsp_rdata, e.rdata);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", bus.req_ready, 1'b1);
    endtask

    // Drive one request on the 2-slave bridge and leave it in SETUP.
    task automatic issue(input logic wr, input logic [8:0] addr,
                         input logic [7:0] wdata, input logic strb);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        tick();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;   // changes outside IDLE must not matter
        bus.req_addr  = 9'h0;
    endtask

    // Full transfer to slave slv with `waits` wait states. The other slave
    // shows PREADY=1, PSLVERR=1 and inverted data throughout; none of it may
    // leak into the response.
    task automatic apb_xfer(input logic wr, input logic [8:0] addr, input logic [7:0] wdata,
                            input logic strb, input int slv, input int waits,
                            input logic [7:0] rdata, input logic slverr);
        logic [1:0] exp_sel;
        logic       exp_strb;
        exp_rsp_t   e;
        exp_sel  = 2'(1 << slv);
        exp_strb = wr ? strb : 1'b0;
        issue(wr, addr, wdata, strb);
        check("setup_bus", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB},
              {exp_sel, 1'b0, wr, addr, wdata, exp_strb});
        check("setup_ready", bus.req_ready, 1'b0);
        bus.PRDATA  = (slv == 0) ? {~rdata, rdata} : {rdata, ~rdata};
        bus.PREADY  = ~exp_sel;
        bus.PSLVERR = ~exp_sel;
        e.err   = slverr;
        e.rdata = (wr || slverr) ? 8'h00 : rdata;
        exp_q.push_back(e);
        tick();
        for (int c = 0; c <= waits; c++) begin
            check("access_bus", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB},
                  {exp_sel, 1'b1, wr, addr, wdata, exp_strb});
            if (c == waits) begin
                bus.PREADY[slv]  = 1'b1;
                bus.PSLVERR[slv] = slverr;
            end
            tick();
        end
        bus.PREADY  = '0;
        bus.PSLVERR = '0;
        check("resp_bus", {bus.rsp_valid, bus.req_ready, bus.PSEL, bus.PENABLE}, {1'b1, 1'b0, 2'b00, 1'b0});
        check("resp_hold", {bus.PADDR, bus.PWDATA}, {addr, wdata});
        tick();
        check("after_resp", {bus.rsp_valid, bus.req_ready}, {1'b0, 1'b1});
    endtask

    // Start a read on slave slv that gets no PREADY; returns in ACCESS cycle 1.
    task automatic start_stuck_read(input logic [8:0] addr, input int slv);
        logic [1:0] exp_sel;
        exp_sel = 2'(1 << slv);
        issue(1'b0, addr, 8'h00, 1'b1);
        check("stuck_setup_psel", bus.PSEL, exp_sel);
        bus.PREADY  = ~exp_sel;
        bus.PRDATA  = 16'h5A5A;
        tick();
    endtask

    task automatic reset_mid_access();
        check("pre_reset_penable", bus.PENABLE, 1'b1);
        #3;
        PRESET = 1'b1;
        #1;
        check("reset_abort", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.req_ready}, 5'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.PREADY  = '0;
        bus.PSLVERR = '0;
        PRESET      = 1'b0;
        #1;
        check("ready_after_abort", bus.req_ready, 1'b1);
        tick();
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_strb   = '0;
        bus.PRDATA     = '0;
        bus.PREADY     = '0;
        bus.PSLVERR    = '0;
        bus3.req_valid = 1'b0;
        bus3.req_write = 1'b0;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;
        bus3.req_strb  = '0;
        bus3.PRDATA    = '0;
        bus3.PREADY    = '0;
        bus3.PSLVERR   = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", bus.req_ready, 1'b0);
        check("reset_outputs", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB,
                                bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, 64'd0);
        check("reset_psel3", bus3.PSEL, 3'b000);
        PRESET = 1'b0;
        #1;
        check("ready_after_reset", bus.req_ready, 1'b1);
        tick();

        // Zero-wait write to slave 1
        apb_xfer(1'b1, 9'h105, 8'hA5, 1'b1, 1, 0, 8'h00, 1'b0);
        // Read from slave 0 with 3 wait states
        apb_xfer(1'b0, 9'h010, 8'h00, 1'b0, 0, 3, 8'h3C, 1'b0);
        // Read with PSLVERR: error and zero data
        apb_xfer(1'b0, 9'h1AA, 8'h00, 1'b0, 1, 1, 8'h77, 1'b1);
        // Write with PSLVERR
        apb_xfer(1'b1, 9'h0FF, 8'h5E, 1'b1, 0, 2, 8'hC3, 1'b1);
        // Write with strobe cleared, wdata carried into PWDATA
        apb_xfer(1'b1, 9'h1FE, 8'h11, 1'b0, 1, 0, 8'h99, 1'b0);

        // 3-slave bridge: index 3 (addr 0x180) is a decode error
        bus3.req_valid = 1'b1;
        bus3.req_addr  = 9'h180;
        exp3_q.push_back('{rdata: 8'h00, err: 1'b1});
        tick();
        bus3.req_valid = 1'b0;
        check("dec_err_resp", {bus3.rsp_valid, bus3.rsp_err, bus3.PSEL, bus3.PENABLE}, {1'b1, 1'b1, 3'b000, 1'b0});
        tick();
        check("dec_err_after", {bus3.rsp_valid, bus3.req_ready, bus3.PSEL}, {1'b0, 1'b1, 3'b000});

        // 3-slave bridge: index 2 (addr 0x100) reaches slave 2
        bus3.req_valid = 1'b1;
        bus3.req_write = 1'b0;
        bus3.req_addr  = 9'h100;
        tick();
        bus3.req_valid = 1'b0;
        check("s2_setup", {bus3.PSEL, bus3.PENABLE, bus3.PWRITE, bus3.PADDR, bus3.PWDATA, bus3.PSTRB},
              {3'b100, 1'b0, 1'b0, 9'h100, 8'h00, 1'b0});
        bus3.PRDATA = {8'h81, 8'h42, 8'h24};
        bus3.PREADY = 3'b100;
        exp3_q.push_back('{rdata: 8'h81, err: 1'b0});
        tick();
        check("s2_access", {bus3.PSEL, bus3.PENABLE}, {3'b100, 1'b1});
        tick();
        bus3.PREADY = '0;
        check("s2_resp", {bus3.rsp_valid, bus3.PSEL}, {1'b1, 3'b000});
        tick();

`ifdef APB_TIMEOUT_EN
        // PREADY held low: 4 ACCESS cycles, then abort with an error
        start_stuck_read(9'h1F0, 1);
        exp_q.push_back('{rdata: 8'h00, err: 1'b1});
        for (int c = 0; c < 4; c++) begin
            check("tmo_access", {bus.PSEL, bus.PENABLE}, {2'b10, 1'b1});
            tick();
        end
        check("tmo_abort", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err}, {2'b00, 1'b0, 1'b1, 1'b1});
        bus.PREADY = '0;
        tick();
        // Fresh transfer to abort by reset
        start_stuck_read(9'h020, 0);
        reset_mid_access();
`else
        // Without a timeout the bridge must still be waiting 100 cycles later
        start_stuck_read(9'h1F0, 1);
        repeat (100) tick();
        check("no_tmo_access", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, {2'b10, 1'b1, 1'b0});
        reset_mid_access();
`endif

        // Normal read after the aborted transfer
        apb_xfer(1'b0, 9'h0A5, 8'h00, 1'b0, 0, 1, 8'hE7, 1'b0);

        repeat (4) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("scoreboard3_empty", 64'(exp3_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so a stuck handshake cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
